// File: rtl/hw_barrier_pkg.sv
// Shared types for the core-side HW barrier initiator.
package hw_barrier_pkg;

  typedef enum logic [1:0] {
    BAR_IDLE    = 2'd0,
    BAR_PENDING = 2'd1,
    BAR_WAITING = 2'd2,
    BAR_RELEASE = 2'd3
  } bar_core_state_e;

endpackage

// File: rtl/hw_barrier_rr_arb.sv
// Round-robin pick of one requester, searching upward from ptr with wrap.
module hw_barrier_rr_arb #(
  parameter int NUM_CORES = 4,
  parameter int PTR_W     = 2
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_CORES-1:0] gnt,
  output logic                 valid,
  output logic [PTR_W-1:0]     idx
);

  always_comb begin
    int c;
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    c     = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      c = int'(ptr) + i;
      if (c >= NUM_CORES) c = c - NUM_CORES;
      if (!valid && req[c]) begin
        valid  = 1'b1;
        idx    = PTR_W'(c);
        gnt[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hw_barrier_core_side.sv
// Core-facing barrier initiator: serialises arrivals into barrier_get pulses,
// parks each core until its event bit fires, then wakes it for one cycle.
module hw_barrier_core_side
  import hw_barrier_pkg::*;
#(
  parameter int NUM_CORES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_CORES-1:0] core_req_i,
  output logic [NUM_CORES-1:0] core_gnt_o,
  output logic [NUM_CORES-1:0] core_wake_o,
  output logic [NUM_CORES-1:0] core_wait_o,
  output logic                 barrier_get_o,
  input  logic [NUM_CORES-1:0] barrier_event_i,
  input  logic                 abort_i,
  output logic                 clear_req_o,
  output logic                 proto_err_o
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [NUM_CORES-1:0] pend;
  logic [NUM_CORES-1:0] arb_gnt;
  logic                 arb_vld;
  logic [PTR_W-1:0]     arb_idx;
  logic [PTR_W-1:0]     ptr_q;
  logic                 clear_req_q;
  logic                 proto_err_q;

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_core
    bar_core_state_e state_q, state_d;

    assign pend[k]        = (state_q == BAR_PENDING);
    assign core_wait_o[k] = pend[k] | (state_q == BAR_WAITING);
    assign core_wake_o[k] = (state_q == BAR_RELEASE);
    // Gated by reset so every output reads 0 while reset is held.
    assign core_gnt_o[k]  = rst_ni & ~abort_i & core_req_i[k] & (state_q == BAR_IDLE);

    always_comb begin
      state_d = state_q;
      if (abort_i) begin
        state_d = BAR_IDLE;
      end else begin
        unique case (state_q)
          BAR_IDLE:    if (core_req_i[k])      state_d = BAR_PENDING;
          BAR_PENDING: if (arb_gnt[k])         state_d = BAR_WAITING;
          BAR_WAITING: if (barrier_event_i[k]) state_d = BAR_RELEASE;
          BAR_RELEASE:                         state_d = BAR_IDLE;
          default:                             state_d = BAR_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= BAR_IDLE;
      else         state_q <= state_d;
    end
  end

  hw_barrier_rr_arb #(
    .NUM_CORES (NUM_CORES),
    .PTR_W     (PTR_W)
  ) u_arb (
    .req   (pend),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .valid (arb_vld),
    .idx   (arb_idx)
  );

  // Each PENDING core yields exactly one get pulse when it wins.
  assign barrier_get_o = |pend;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      clear_req_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      clear_req_q <= abort_i;
      proto_err_q <= proto_err_q | (~abort_i & (|(pend & barrier_event_i)));
      if (abort_i)
        ptr_q <= '0;
      else if (arb_vld)
        ptr_q <= (arb_idx == PTR_W'(NUM_CORES - 1)) ? '0 : arb_idx + PTR_W'(1);
    end
  end

  assign clear_req_o = clear_req_q;
  assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_hw_barrier_core_side.sv
// Directed + random bench for hw_barrier_core_side against a bit-vector reference model.
module tb_hw_barrier_core_side;
  localparam int NC = 4;
  localparam int OW = 3 * NC + 3;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [NC-1:0] core_req_i, core_gnt_o, core_wake_o, core_wait_o, barrier_event_i;
  logic          barrier_get_o, abort_i, clear_req_o, proto_err_o;

  always #5 clk_i = ~clk_i;

  hw_barrier_core_side #(.NUM_CORES(NC)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .core_req_i      (core_req_i),
    .core_gnt_o      (core_gnt_o),
    .core_wake_o     (core_wake_o),
    .core_wait_o     (core_wait_o),
    .barrier_get_o   (barrier_get_o),
    .barrier_event_i (barrier_event_i),
    .abort_i         (abort_i),
    .clear_req_o     (clear_req_o),
    .proto_err_o     (proto_err_o)
  );

  // Environment: barrier counter that fires the team mask once team gets have arrived.
  logic          use_cnt;
  int            team, cnt;
  logic [NC-1:0] team_mask, ev_drv, ev_force;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                               cnt <= 0;
    else if (clear_req_o || (team != 0 && cnt == team)) cnt <= 0;
    else if (barrier_get_o)                    cnt <= cnt + 1;
  end

  always_comb begin
    barrier_event_i = ev_drv | ev_force;
    if (use_cnt && team != 0 && cnt == team) barrier_event_i = barrier_event_i | team_mask;
  end

  // Reference model: which cores are queued for arbitration, counted and parked, or waking.
  logic [NC-1:0] m_q, m_c, m_w;
  int            m_ptr;
  logic          m_clr, m_err;
  int            checks = 0, errors = 0, cyc = 0;
  string         tag;

  task automatic cycle();
    logic [NC-1:0] gnt_e, ev;
    logic [OW-1:0] act, exp_v;
    int w, best, d;
    #1;
    ev    = barrier_event_i;
    gnt_e = abort_i ? '0 : (core_req_i & ~(m_q | m_c | m_w));
    act   = {core_gnt_o, core_wake_o, core_wait_o, barrier_get_o, clear_req_o, proto_err_o};
    exp_v = {gnt_e, m_w, m_q | m_c, |m_q, m_clr, m_err};
    checks++;
    assert (act === exp_v) else begin
      errors++;
      $error("FAIL %s cyc=%0d gnt/wake/wait/get/clr/err got=%b exp=%b", tag, cyc, act, exp_v);
    end
    w = -1; best = NC;
    for (int k = 0; k < NC; k++)
      if (m_q[k]) begin
        d = (k - m_ptr + NC) % NC;
        if (d < best) begin best = d; w = k; end
      end
    m_clr = abort_i;
    if (abort_i) begin
      m_q = '0; m_c = '0; m_w = '0; m_ptr = 0;
    end else begin
      m_err = m_err | (|(m_q & ev));
      m_w   = m_c & ev;
      m_c   = m_c & ~ev;
      if (w >= 0) begin m_q[w] = 1'b0; m_c[w] = 1'b1; m_ptr = (w + 1) % NC; end
      m_q = m_q | gnt_e;
    end
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    core_req_i = '0; ev_drv = '0; ev_force = '0; abort_i = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic [NC-1:0] req_n;
    rst_ni = 1'b0; core_req_i = '0; abort_i = 1'b0;
    use_cnt = 1'b0; team = 0; team_mask = '0; ev_drv = '0; ev_force = '0;
    m_q = '0; m_c = '0; m_w = '0; m_ptr = 0; m_clr = 1'b0; m_err = 1'b0;

    tag = "reset";
    @(negedge clk_i); #1;
    checks++;
    assert ({core_gnt_o, core_wake_o, core_wait_o, barrier_get_o, clear_req_o, proto_err_o} === '0)
      else begin errors++; $error("FAIL reset outputs not zero"); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle(2);

    // All four arrive together, team of 4: gets in order 0..3, one shared wake.
    tag = "all4"; use_cnt = 1'b1; team = 4; team_mask = 4'b1111;
    core_req_i = 4'b1111; cycle();
    idle(9);

    // Single core, team of 1, event looped back from the counter.
    tag = "single"; team = 1; team_mask = 4'b0001;
    core_req_i = 4'b0001; cycle();
    idle(5);

    // Core 1 alone leaves ptr at 2; then cores 0 and 3 must be served 3 first.
    tag = "prior"; team_mask = 4'b0010;
    core_req_i = 4'b0010; cycle();
    idle(5);
    tag = "rr_order"; use_cnt = 1'b0;
    core_req_i = 4'b1001; cycle();
    idle(1);
    ev_drv = 4'b1000; cycle();
    ev_drv = 4'b0001; cycle();
    idle(3);
    // ptr should now be 1: core 1 wins over core 0.
    tag = "rr_ptr1";
    core_req_i = 4'b0011; cycle();
    idle(1);
    ev_drv = 4'b0010; cycle();
    ev_drv = 4'b0001; cycle();
    idle(3);

    // Abort with cores 1,2 parked; core 3 request in abort cycle is refused and held.
    tag = "abort"; use_cnt = 1'b1; team = 0;
    core_req_i = 4'b0110; cycle();
    idle(3);
    core_req_i = 4'b1000; abort_i = 1'b1; cycle();
    abort_i = 1'b0; cycle();
    core_req_i = '0; cycle();
    ev_drv = 4'b1000; cycle();
    idle(3);

    // Event while core 0 is still PENDING: sticky error, core 0 still completes.
    tag = "proto_err"; use_cnt = 1'b0;
    core_req_i = 4'b0001; cycle();
    core_req_i = '0; ev_force = 4'b0001; cycle();
    ev_force = '0; ev_drv = 4'b0001; cycle();
    idle(4);

    // Reset mid-barrier with three cores parked.
    tag = "midreset";
    core_req_i = 4'b0111; cycle();
    idle(4);
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    assert ({core_gnt_o, core_wake_o, core_wait_o, barrier_get_o, clear_req_o, proto_err_o} === '0)
      else begin errors++; $error("FAIL midreset outputs not zero"); end
    m_q = '0; m_c = '0; m_w = '0; m_ptr = 0; m_clr = 1'b0; m_err = 1'b0;
    @(negedge clk_i); @(negedge clk_i);
    rst_ni = 1'b1;
    idle(4);

    // Random traffic: requests held until granted, random events, rare aborts.
    tag = "random";
    for (int i = 0; i < 500; i++) begin
      for (int k = 0; k < NC; k++)
        req_n[k] = (core_req_i[k] && !m_q[k]) ||
                   (!(m_q[k] | m_c[k] | m_w[k]) && ($urandom_range(0, 3) == 0));
      core_req_i = req_n;
      ev_drv     = NC'($urandom & $urandom);
      abort_i    = ($urandom_range(0, 39) == 0);
      cycle();
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
